// File: rtl/dvp_pxl_dma_ctrl_pkg.sv
// Shared types and constants for the DVP pixel write-DMA sequencer.
// Holds the FSM encoding, AXI response codes and the burst sizing helpers.
package dvp_pxl_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    ADDR      = 3'd2,
    DATA      = 3'd3,
    RESP      = 3'd4
  } dma_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // AWSIZE encodes bytes per beat as log2
  function automatic int awsize_f(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int burst_bytes_f(input int burst_len, input int data_w);
    return burst_len * (data_w / 8);
  endfunction

endpackage

// File: rtl/dvp_dma_beat_cnt.sv
// Counts accepted W beats within a burst and flags the final beat.
// Wraps to zero on the last handshake so the next burst starts clean.
module dvp_dma_beat_cnt #(
  parameter int BURST_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic beat_en,
  output logic wlast
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat_cnt;

  assign wlast = active & (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (beat_en) begin
      beat_cnt <= wlast ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/dvp_pxl_dma_ctrl.sv
// Write-DMA sequencer: drains the DVP pixel FIFO into memory as fixed-length
// AXI4 INCR bursts, one frame per accepted frame_start_i.
module dvp_pxl_dma_ctrl
  import dvp_pxl_dma_ctrl_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int ADDR_W            = 32,
  parameter int MST_ID_W          = 5,
  parameter int MST_ID            = 0,
  parameter int TRANS_DATA_LEN_W  = 8,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_RESP_W      = 2,
  parameter int BURST_LEN         = 16,
  parameter int FRAME_WORDS       = 19200,
  parameter int LVL_W             = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dvp_en_i,
  input  logic [ADDR_W-1:0]            pxl_mem_base_i,
  input  logic                         frame_start_i,
  input  logic [LVL_W-1:0]             fifo_lvl_i,
  input  logic [DATA_W-1:0]            pxl_data_i,
  input  logic                         pxl_valid_i,
  output logic                         pxl_ready_o,
  output logic [MST_ID_W-1:0]          m_awid_o,
  output logic [ADDR_W-1:0]            m_awaddr_o,
  output logic [TRANS_DATA_LEN_W-1:0]  m_awlen_o,
  output logic [TRANS_DATA_SIZE_W-1:0] m_awsize_o,
  output logic                         m_awvalid_o,
  input  logic                         m_awready_i,
  output logic [DATA_W-1:0]            m_wdata_o,
  output logic                         m_wlast_o,
  output logic                         m_wvalid_o,
  input  logic                         m_wready_i,
  input  logic [TRANS_RESP_W-1:0]      m_bresp_i,
  input  logic                         m_bvalid_i,
  output logic                         m_bready_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         err_o
);

  localparam int WC_W = $clog2(FRAME_WORDS + 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(burst_bytes_f(BURST_LEN, DATA_W));
  localparam logic [WC_W-1:0]   BURST_WORDS = WC_W'(BURST_LEN);
  localparam logic [WC_W-1:0]   FRAME_TOTAL = WC_W'(FRAME_WORDS);
  localparam logic [LVL_W:0]    BURST_LVL   = (LVL_W + 1)'(BURST_LEN);

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic              busy_q, done_q, err_q;

  logic lvl_ok, w_hs, b_hs, frame_last, start_ok;

  assign lvl_ok     = {1'b0, fifo_lvl_i} >= BURST_LVL;
  assign w_hs       = (state_q == DATA) & pxl_valid_i & m_wready_i;
  assign b_hs       = (state_q == RESP) & m_bvalid_i;
  assign frame_last = (word_cnt_q + BURST_WORDS) == FRAME_TOTAL;
  assign start_ok   = (state_q == IDLE) & frame_start_i & dvp_en_i;

  assign m_awid_o     = MST_ID_W'(MST_ID);
  assign m_awlen_o    = TRANS_DATA_LEN_W'(BURST_LEN - 1);
  assign m_awsize_o   = TRANS_DATA_SIZE_W'(awsize_f(DATA_W));
  assign m_awaddr_o   = addr_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign err_o        = err_q;

  dvp_dma_beat_cnt #(
    .BURST_LEN (BURST_LEN)
  ) u_beat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state_q == DATA),
    .beat_en (w_hs),
    .wlast   (m_wlast_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Once AW is issued, dvp_en_i is ignored until the B response retires the burst
  always_comb begin
    state_d     = state_q;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_wdata_o   = '0;
    pxl_ready_o = 1'b0;
    m_bready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_i && dvp_en_i) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (lvl_ok)         state_d = ADDR;
        else if (!dvp_en_i) state_d = IDLE;
      end
      ADDR: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) state_d = DATA;
      end
      DATA: begin
        m_wvalid_o  = pxl_valid_i;
        m_wdata_o   = pxl_data_i;
        pxl_ready_o = m_wready_i;
        if (w_hs && m_wlast_o) state_d = RESP;
      end
      RESP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) begin
          if (frame_last || !dvp_en_i) state_d = IDLE;
          else                         state_d = WAIT_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= b_hs & frame_last;
      if (start_ok) begin
        addr_q     <= pxl_mem_base_i;
        word_cnt_q <= '0;
        err_q      <= 1'b0;
      end else if (b_hs) begin
        addr_q     <= addr_q + BURST_BYTES;
        word_cnt_q <= word_cnt_q + BURST_WORDS;
        if (m_bresp_i != TRANS_RESP_W'(RESP_OKAY)) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_pxl_dma_ctrl.sv
// Directed bench for dvp_pxl_dma_ctrl with a 64-word frame of 16-beat bursts.
// The bench acts as pixel FIFO and AXI slave and checks every handshake.
module tb_dvp_pxl_dma_ctrl;

  localparam logic [31:0] DATA_BASE = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dvp_en_i;
  logic [31:0] pxl_mem_base_i;
  logic        frame_start_i;
  logic [7:0]  fifo_lvl_i;
  logic [31:0] pxl_data_i;
  logic        pxl_valid_i;
  logic        pxl_ready_o;
  logic [4:0]  m_awid_o;
  logic [31:0] m_awaddr_o;
  logic [7:0]  m_awlen_o;
  logic [2:0]  m_awsize_o;
  logic        m_awvalid_o;
  logic        m_awready_i;
  logic [31:0] m_wdata_o;
  logic        m_wlast_o;
  logic        m_wvalid_o;
  logic        m_wready_i;
  logic [1:0]  m_bresp_i;
  logic        m_bvalid_i;
  logic        m_bready_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        err_o;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int word_ctr = 0;
  int pop_cnt = 0;

  always #5 clk = ~clk;

  dvp_pxl_dma_ctrl #(
    .BURST_LEN   (16),
    .FRAME_WORDS (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dvp_en_i       (dvp_en_i),
    .pxl_mem_base_i (pxl_mem_base_i),
    .frame_start_i  (frame_start_i),
    .fifo_lvl_i     (fifo_lvl_i),
    .pxl_data_i     (pxl_data_i),
    .pxl_valid_i    (pxl_valid_i),
    .pxl_ready_o    (pxl_ready_o),
    .m_awid_o       (m_awid_o),
    .m_awaddr_o     (m_awaddr_o),
    .m_awlen_o      (m_awlen_o),
    .m_awsize_o     (m_awsize_o),
    .m_awvalid_o    (m_awvalid_o),
    .m_awready_i    (m_awready_i),
    .m_wdata_o      (m_wdata_o),
    .m_wlast_o      (m_wlast_o),
    .m_wvalid_o     (m_wvalid_o),
    .m_wready_i     (m_wready_i),
    .m_bresp_i      (m_bresp_i),
    .m_bvalid_i     (m_bvalid_i),
    .m_bready_o     (m_bready_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [31:0] base);
    @(negedge clk);
    pxl_mem_base_i = base;
    dvp_en_i       = 1'b1;
    frame_start_i  = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
    #1;
    chk("busy_on_start", busy_o, 1'b1);
    chk("err_clr_on_start", err_o, 1'b0);
  endtask

  // One burst as seen from the AXI slave side; optional enable drop,
  // mid-frame start pulse and reset injection at a given beat count.
  task automatic do_burst(input logic [31:0] exp_addr, input bit stall, input logic [1:0] resp,
                          input int drop_beat, input int fs_beat, input int rst_beat,
                          output logic done_seen);
    int  wait_cyc;
    int  beat;
    bit  fs_sent;
    done_seen   = 1'b0;
    m_awready_i = 1'b0;
    wait_cyc    = 0;
    while (m_awvalid_o !== 1'b1 && wait_cyc < 200) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    chk("aw_timeout", wait_cyc < 200, 1'b1);
    chk("awaddr", m_awaddr_o, exp_addr);
    chk("awlen_awsize_awid", {m_awlen_o, m_awsize_o, m_awid_o}, {8'd15, 3'd2, 5'd0});
    if (stall) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        #1;
        chk("aw_hold", {m_awvalid_o, m_awaddr_o}, {1'b1, exp_addr});
      end
    end
    m_awready_i = 1'b1;
    @(negedge clk);
    m_awready_i = 1'b0;
    beat     = 0;
    fs_sent  = 1'b0;
    wait_cyc = 0;
    while (beat < 16 && wait_cyc < 500) begin
      m_wready_i  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      pxl_valid_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (m_wvalid_o && m_wready_i) begin
        chk("wdata", m_wdata_o, DATA_BASE + 32'(word_ctr));
        chk("wlast", m_wlast_o, beat == 15);
        if (pxl_ready_o && pxl_valid_i) pop_cnt++;
        word_ctr++;
        beat++;
        if (beat == drop_beat) dvp_en_i = 1'b0;
        if (beat == rst_beat) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          #1;
          chk("rst_ctrl_outs", {m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o, pxl_ready_o,
                                busy_o, frame_done_o, err_o}, 8'h00);
          chk("rst_addr_data", {m_awaddr_o, m_wdata_o}, 64'h0);
          return;
        end
      end
      if (beat == fs_beat && !fs_sent) begin
        frame_start_i = 1'b1;
        fs_sent       = 1'b1;
      end else begin
        frame_start_i = 1'b0;
      end
      @(negedge clk);
      pxl_data_i = DATA_BASE + 32'(word_ctr);
      wait_cyc++;
    end
    frame_start_i = 1'b0;
    m_wready_i    = 1'b0;
    pxl_valid_i   = 1'b1;
    #1;
    chk("w_beats", beat, 16);
    chk("bready", m_bready_o, 1'b1);
    m_bresp_i  = resp;
    m_bvalid_i = 1'b1;
    @(negedge clk);
    m_bvalid_i = 1'b0;
    m_bresp_i  = 2'b00;
    #1;
    done_seen = frame_done_o;
  endtask

  task automatic run_frame(input logic [31:0] base, input bit stall, input int err_burst,
                           input int fs_burst);
    logic d;
    for (int i = 0; i < 4; i++) begin
      do_burst(base + 32'(i * 64), stall, (i == err_burst) ? 2'b10 : 2'b00, -1,
               (i == fs_burst) ? 3 : -1, -1, d);
      chk($sformatf("done_after_b%0d", i), d, i == 3);
      if (i == err_burst) chk("err_rise", err_o, 1'b1);
    end
    chk("busy_end", busy_o, 1'b0);
    @(negedge clk);
    #1;
    chk("done_one_cycle", frame_done_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic d;
    bit   seen;
    rst_n          = 1'b0;
    dvp_en_i       = 1'b0;
    pxl_mem_base_i = 32'h0;
    frame_start_i  = 1'b0;
    fifo_lvl_i     = 8'd64;
    pxl_data_i     = DATA_BASE;
    pxl_valid_i    = 1'b1;
    m_awready_i    = 1'b0;
    m_wready_i     = 1'b0;
    m_bresp_i      = 2'b00;
    m_bvalid_i     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o, pxl_ready_o,
                       busy_o, frame_done_o, err_o}, 8'h00);
    chk("reset_awaddr", m_awaddr_o, 32'h0);
    chk("reset_consts", {m_awlen_o, m_awsize_o, m_awid_o}, {8'd15, 3'd2, 5'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // Frame A: clean run from 0x8000_0000
    pop_cnt = 0;
    start_frame(32'h8000_0000);
    run_frame(32'h8000_0000, 1'b0, -1, -1);
    chk("pops_frame_a", pop_cnt, 64);

    // Frame B: FIFO level one short of a burst, then random stalls
    pop_cnt    = 0;
    fifo_lvl_i = 8'd15;
    start_frame(32'h4000_0000);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (m_awvalid_o) seen = 1'b1;
    end
    chk("no_aw_below_level", seen, 1'b0);
    fifo_lvl_i = 8'd16;
    run_frame(32'h4000_0000, 1'b1, -1, -1);
    chk("pops_frame_b", pop_cnt, 64);
    fifo_lvl_i = 8'd64;

    // Frame C: SLVERR on burst 2, stray frame_start mid-frame
    start_frame(32'h8000_0000);
    run_frame(32'h8000_0000, 1'b0, 1, 2);
    chk("err_sticky_after_done", err_o, 1'b1);

    // frame_start with enable low in IDLE is ignored
    @(negedge clk);
    dvp_en_i      = 1'b0;
    frame_start_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (m_awvalid_o || busy_o) seen = 1'b1;
    end
    chk("ignored_start_idle", seen, 1'b0);
    chk("err_kept_on_ignored", err_o, 1'b1);

    // Frame D: enable dropped during first burst
    start_frame(32'h1234_5600);
    do_burst(32'h1234_5600, 1'b0, 2'b00, 5, -1, -1, d);
    chk("no_done_on_abort", d, 1'b0);
    chk("busy_after_abort", busy_o, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (m_awvalid_o || frame_done_o) seen = 1'b1;
    end
    chk("idle_after_abort", seen, 1'b0);

    // Reset at beat 7, then restart at a base that wraps the address space
    start_frame(32'h2000_0000);
    do_burst(32'h2000_0000, 1'b0, 2'b00, -1, -1, 7, d);
    @(negedge clk);
    rst_n      = 1'b1;
    m_wready_i = 1'b0;
    pxl_data_i = DATA_BASE + 32'(word_ctr);
    start_frame(32'hFFFF_FF80);
    run_frame(32'hFFFF_FF80, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
